// File: rtl/simon_show_state_if.sv
// Bundle between the game controller and the Simon playback stage.
// The controller (master) drives the enable and the target sequence; the
// playback stage (slave) returns the lamp drive, the colour strobe for the
// buzzer and the completion flag.
interface simon_show_state_if;
    logic        en;
    logic [31:0] sequence_val;
    logic [3:0]  sequence_len;
    logic [3:0]  led;
    logic [1:0]  colour_out;
    logic        colour_valid;
    logic        complete_show;

    modport master (
        output en,
        output sequence_val,
        output sequence_len,
        input  led,
        input  colour_out,
        input  colour_valid,
        input  complete_show
    );

    modport slave (
        input  en,
        input  sequence_val,
        input  sequence_len,
        output led,
        output colour_out,
        output colour_valid,
        output complete_show
    );
endinterface

// File: rtl/simon_show_state.sv
// Simon playback stage: flashes a captured colour sequence on four one-hot
// LEDs with ON_CYCLES lit / OFF_CYCLES dark per colour, then raises
// complete_show until the controller drops en.
// Optional feature macro: SHOW_LEAD_IN_EN -- inserts a dark LEAD phase of
// OFF_CYCLES cycles before the first colour (zero-length runs skip it).
module simon_show_state #(
    parameter int ON_CYCLES  = 8,
    parameter int OFF_CYCLES = 4,
    parameter int CNT_W      = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    simon_show_state_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        ON   = 3'd2,
        OFF  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    state_t           state, state_next;
    logic [31:0]      shadow_seq, seq_next;
    logic [3:0]       shadow_len, len_next;
    logic [CNT_W-1:0] timer, timer_next;
    logic [3:0]       index, index_next;

    logic [3:0]       pos;
    logic [31:0]      seq_shifted;
    logic [1:0]       colour_sel;
    logic [3:0]       led_next;
    logic             valid_next;
    logic             complete_next;

    logic [3:0]       led_reg;
    logic [1:0]       colour_reg;
    logic             valid_reg;
    logic             complete_reg;

    // Next-state, shadow capture, phase timer and registered-output values.
    // Outputs are derived from the *next* state so they appear on the same
    // edge the FSM enters a phase (colour 0 is visible right after capture).
    always_comb begin
        state_next  = state;
        seq_next    = shadow_seq;
        len_next    = shadow_len;
        timer_next  = timer;
        index_next  = index;

        case (state)
            IDLE: begin
                if (bus.en) begin
                    seq_next   = bus.sequence_val;
                    len_next   = bus.sequence_len;
                    index_next = '0;
                    timer_next = '0;
                    if (bus.sequence_len == 4'd0) begin
                        state_next = DONE;
                    end else begin
`ifdef SHOW_LEAD_IN_EN
                        state_next = LEAD;
`else
                        state_next = ON;
`endif
                    end
                end
            end
`ifdef SHOW_LEAD_IN_EN
            LEAD: begin
                if (timer == OFF_LAST) begin
                    timer_next = '0;
                    state_next = ON;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
`endif
            ON: begin
                if (timer == ON_LAST) begin
                    timer_next = '0;
                    state_next = OFF;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            OFF: begin
                if (timer == OFF_LAST) begin
                    timer_next = '0;
                    if (index == shadow_len - 4'd1) begin
                        state_next = DONE;
                    end else begin
                        index_next = index + 4'd1;
                        state_next = ON;
                    end
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Dropping en aborts from anywhere; no partial completion is reported.
        if (!bus.en && state != IDLE) begin
            state_next = IDLE;
            timer_next = '0;
            index_next = '0;
        end

        // Element k sits at pair (len-1-k): first played = oldest shifted in.
        pos           = len_next - 4'd1 - index_next;
        seq_shifted   = seq_next >> {pos, 1'b0};
        colour_sel    = seq_shifted[1:0];

        led_next      = (state_next == ON) ? (4'b0001 << colour_sel) : 4'b0000;
        valid_next    = (state_next == ON) && (state != ON);
        complete_next = (state_next == DONE);
    end

    // FSM state, shadow copy of the sequence, phase timer and colour index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shadow_seq <= '0;
            shadow_len <= '0;
            timer      <= '0;
            index      <= '0;
        end else begin
            state      <= state_next;
            shadow_seq <= seq_next;
            shadow_len <= len_next;
            timer      <= timer_next;
            index      <= index_next;
        end
    end

    // Registered outputs; colour_out holds the last shown colour between flashes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_reg      <= '0;
            colour_reg   <= '0;
            valid_reg    <= 1'b0;
            complete_reg <= 1'b0;
        end else begin
            led_reg      <= led_next;
            valid_reg    <= valid_next;
            complete_reg <= complete_next;
            if (valid_next) begin
                colour_reg <= colour_sel;
            end
        end
    end

    assign bus.led           = led_reg;
    assign bus.colour_out    = colour_reg;
    assign bus.colour_valid  = valid_reg;
    assign bus.complete_show = complete_reg;

endmodule

// File: tb/tb_simon_show_state.sv
// Self-checking bench for simon_show_state (ON_CYCLES=3, OFF_CYCLES=2).
// Expected per-cycle outputs are generated from the sequence definition and
// queued when a run is started, then popped and compared each cycle.
// Build with SHOW_LEAD_IN_EN defined to exercise the lead-in variant.
module tb_simon_show_state;

    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int P   = ON + OFF;
`ifdef SHOW_LEAD_IN_EN
    localparam int LEAD_CYC = OFF;
`else
    localparam int LEAD_CYC = 0;
`endif

    typedef struct packed {
        logic [3:0] led;
        logic       valid;
        logic [1:0] colour;
        logic       done;
    } exp_t;

    logic clk;
    logic rst_n;
    simon_show_state_if bus();

    exp_t sb[$];
    int   checks;
    int   failures;

    simon_show_state #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for the cycle following edge T0+i of a run.
    function automatic exp_t model(input logic [31:0] seq, input int len, input int i);
        exp_t e;
        int t;
        int k;
        int ph;
        logic [31:0] sh;
        e = '0;
        if (len == 0) begin
            e.done = 1'b1;
            return e;
        end
        t = i - LEAD_CYC;
        if (t < 0) return e;
        k  = t / P;
        ph = t % P;
        if (k >= len) begin
            e.done = 1'b1;
        end else if (ph < ON) begin
            sh       = seq >> (2 * (len - 1 - k));
            e.colour = sh[1:0];
            e.led    = 4'b0001 << sh[1:0];
            e.valid  = (ph == 0);
        end
        return e;
    endfunction

    // Start a run at the coming edge and queue n cycles of expectations.
    task automatic start(input logic [31:0] seq, input int len, input int n);
        @(negedge clk);
        bus.sequence_val = seq;
        bus.sequence_len = 4'(len);
        bus.en           = 1'b1;
        for (int i = 0; i < n; i++) sb.push_back(model(seq, len, i));
        $display("run seq=%08h len=%0d cycles=%0d", seq, len, n);
    endtask

    task automatic drain(input string name, input int n);
        exp_t e;
        for (int i = 0; i < n && sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            check({name, ".led"},      32'(bus.led),           32'(e.led));
            check({name, ".valid"},    32'(bus.colour_valid),  32'(e.valid));
            check({name, ".complete"}, 32'(bus.complete_show), 32'(e.done));
            if (e.valid) check({name, ".colour"}, 32'(bus.colour_out), 32'(e.colour));
        end
    endtask

    task automatic go_idle(input string name);
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        check({name, ".idle_led"},  32'(bus.led),           32'd0);
        check({name, ".idle_done"}, 32'(bus.complete_show), 32'd0);
    endtask

    initial begin
        logic [31:0] rseq;
        int          rlen;
        checks   = 0;
        failures = 0;
        rst_n            = 1'b0;
        bus.en           = 1'b0;
        bus.sequence_val = '0;
        bus.sequence_len = '0;
        repeat (2) @(negedge clk);
        check("reset.led",      32'(bus.led),           32'd0);
        check("reset.colour",   32'(bus.colour_out),    32'd0);
        check("reset.valid",    32'(bus.colour_valid),  32'd0);
        check("reset.complete", 32'(bus.complete_show), 32'd0);
        rst_n = 1'b1;

        // Basic playback 0x23/len=3, plus hold of complete_show.
        start(32'h23, 3, LEAD_CYC + 3 * P + 4);
        drain("basic", 1000);
        go_idle("basic");

        // Zero length: straight to done, never lit.
        start(32'h0, 0, 6);
        drain("zero", 1000);
        go_idle("zero");

        // Inputs change one cycle after capture: shadow copy must be used.
        start(32'h23, 3, LEAD_CYC + 3 * P + 2);
        drain("chg", 1);
        bus.sequence_val = 32'hFFFF_FFFF;
        bus.sequence_len = 4'd15;
        drain("chg", 1000);
        go_idle("chg");

        // Abort during second ON phase, then restart from colour 0.
        start(32'h1B, 4, LEAD_CYC + P + 2);
        drain("abort", 1000);
        bus.en = 1'b0;
        for (int i = 0; i < 4 * P; i++) sb.push_back(exp_t'(0));
        drain("abort_dark", 1000);
        start(32'h1B, 4, LEAD_CYC + 4 * P + 2);
        drain("restart", 1000);
        go_idle("restart");

        // A few random sequences.
        for (int r = 0; r < 3; r++) begin
            rseq = $urandom;
            rlen = $urandom_range(1, 6);
            start(rseq, rlen, LEAD_CYC + rlen * P + 2);
            drain("rand", 1000);
            go_idle("rand");
        end

        // Maximum length.
        start(32'h1B1B_1B1B, 15, LEAD_CYC + 15 * P + 3);
        drain("maxlen", 1000);
        go_idle("maxlen");

        // Asynchronous reset while a colour is lit: outputs clear without a clock.
        start(32'h23, 3, LEAD_CYC + 2);
        drain("pre_rst", 1000);
        rst_n = 1'b0;
        #1;
        check("async_rst.led",      32'(bus.led),           32'd0);
        check("async_rst.valid",    32'(bus.colour_valid),  32'd0);
        check("async_rst.complete", 32'(bus.complete_show), 32'd0);
        check("async_rst.colour",   32'(bus.colour_out),    32'd0);
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst.led", 32'(bus.led), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
